qos_wrr_arbiter: RTL
====================

// Module: qos_wrr_arbiter
// PURPOSE
//  Weighted round-robin arbiter for the four per-class QoS FIFOs (ff0..ff3).
//  Sits directly upstream of the FIFO-to-main-FIFO connector and produces its
//  one-hot GRAND and POPDATOCF strobe. Each class gets up to WEIGHTn
//  consecutive grants per turn. Grants stop while the main FIFO is almost full.
// PARAMETERS
//  WEIGHT_W  4  width of each per-class weight/credit value
// PORTS
//  CLOCK            in   1         single clock, rising edge
//  RESET            in   1         asynchronous, active-high reset
//  EMPTYff          in   4         bit n = FIFO ffn empty
//  MAIN_ALMOSTFULL  in   1         main FIFO cannot take another push
//  WEIGHT0..WEIGHT3 in   WEIGHT_W  grants per turn for class n; 0 = class disabled
//  GRAND            out  4         one-hot grant, bit n selects ffn; 0000 = none
//  POPDATOCF        out  1         pop/push strobe, high exactly when GRAND != 0
// BEHAVIOUR
//  - All outputs are registered. RESET asserts asynchronously and takes effect
//    immediately: GRAND=0000, POPDATOCF=0, state=IDLE, PTR=0, all credits=0.
//  - Eligible(n) = !EMPTYff[n] && WEIGHTn != 0.
//  - FSM states:
//    - IDLE: decide on each clock edge. If MAIN_ALMOSTFULL=0 and any class is
//      eligible, select channel c, register GRAND=onehot(c) and POPDATOCF=1,
//      and go to GRANT. Otherwise stay in IDLE with outputs 0.
//    - GRANT: lasts exactly 1 cycle; the pop happens during this cycle.
//      Next state is WAIT with GRAND=0000 and POPDATOCF=0.
//    - WAIT: lasts exactly 1 cycle so that the FIFO EMPTY and ALMOSTFULL flags
//      reflect the pop. Next state is IDLE.
//    - Peak throughput: one grant per 3 cycles. A 1-entry FIFO is never popped twice.
//  - Selection: search PTR, PTR+1, PTR+2, PTR+3 (mod 4) and take the first
//    eligible class c.
//  - Credit handling, applied at the grant edge:
//    - If c==PTR and credit!=0: credit <= credit-1.
//    - Otherwise (new class, or credit was 0): credit <= WEIGHTc-1.
//    - WEIGHTc is sampled only at this load point. Later changes apply on the
//      class's next turn.
//    - After the update, if credit==0 then PTR <= c+1 (mod 4, wrap 3->0).
//      Otherwise PTR <= c.
//  - A class that goes empty mid-turn forfeits its remaining credit. The search
//    then moves past it.
//  - MAIN_ALMOSTFULL is sampled only in IDLE. Once GRANT is entered it always
//    completes.
//  - The credit counter is WEIGHT_W bits wide and never underflows. A weight of
//    2^WEIGHT_W-1 gives that many grants.
//  - RESET during GRANT or WAIT aborts the operation: outputs drop to 0 in the
//    same cycle and no further grant is issued until RESET deasserts.
//  - The first decision happens on the first rising edge after RESET deasserts.
// TESTING
//  1. Reset: RESET=1 in mid-GRANT -> GRAND=0000 and POPDATOCF=0 at once, with no
//     clock edge needed. After release, first grant goes to ff0 if it is eligible.
//  2. Single class: only ff2 non-empty, WEIGHT2=3 -> GRAND=0100 every 3rd cycle,
//     indefinitely. PTR advances after each 3rd grant, then wraps back to ff2.
//  3. WRR order: all FIFOs full, weights 3,1,2,1 -> grant sequence
//     0,0,0,1,2,2,3,0,0,0,... with POPDATOCF=1 on every grant cycle.
//  4. Backpressure: hold MAIN_ALMOSTFULL=1 for 10 cycles -> no grants. Release it
//     -> grant on the first IDLE edge. Credit and PTR are unchanged by the stall.
//  5. Disabled/empty: WEIGHT1=0 with ff1 full -> ff1 is never granted. ff0 with
//     weight 4 holding 2 words -> 2 grants, then ff2 is served (credit forfeited).
//  6. Weight change mid-turn: WEIGHT0 3->1 after the first ff0 grant -> the
//     current turn still gives 3 grants, the next ff0 turn gives 1.

Source files
------------

// File: rtl/qos_wrr_arbiter.sv
// Weighted round-robin arbiter across four QoS class FIFOs.
// Issues one registered one-hot grant per IDLE->GRANT->WAIT cycle.
module qos_wrr_arbiter #(
  parameter int WEIGHT_W = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [3:0]          EMPTYff,
  input  logic                MAIN_ALMOSTFULL,
  input  logic [WEIGHT_W-1:0] WEIGHT0,
  input  logic [WEIGHT_W-1:0] WEIGHT1,
  input  logic [WEIGHT_W-1:0] WEIGHT2,
  input  logic [WEIGHT_W-1:0] WEIGHT3,
  output logic [3:0]          GRAND,
  output logic                POPDATOCF
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [WEIGHT_W-1:0] ONE  = WEIGHT_W'(1);
  localparam logic [WEIGHT_W-1:0] ZERO = '0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_ptr;
  logic [1:0]          w_ptr_nxt;
  logic [WEIGHT_W-1:0] r_credit;
  logic [WEIGHT_W-1:0] w_credit_nxt;
  logic [3:0]          r_grand;
  logic [3:0]          w_grand_nxt;
  logic                r_pop;
  logic                w_pop_nxt;

  logic [WEIGHT_W-1:0] w_weight [4];
  logic [3:0]          w_elig;
  logic                w_found;
  logic [1:0]          w_sel;
  logic [WEIGHT_W-1:0] w_credit_upd;
  logic [1:0]          w_ptr_upd;

  assign w_weight[0] = WEIGHT0;
  assign w_weight[1] = WEIGHT1;
  assign w_weight[2] = WEIGHT2;
  assign w_weight[3] = WEIGHT3;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_elig[n] = !EMPTYff[n] && (w_weight[n] != ZERO);
    end
  end

  // Walk downwards so the class closest to PTR wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_sel   = r_ptr + 2'(i);
      end
    end
  end

  // Continue the current turn, else reload from the sampled weight.
  always_comb begin
    if ((w_sel == r_ptr) && (r_credit != ZERO)) begin
      w_credit_upd = r_credit - ONE;
    end else begin
      w_credit_upd = w_weight[w_sel] - ONE;
    end
    if (w_credit_upd == ZERO) begin
      w_ptr_upd = w_sel + 2'd1;
    end else begin
      w_ptr_upd = w_sel;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_credit_nxt = r_credit;
    w_grand_nxt  = 4'b0000;
    w_pop_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!MAIN_ALMOSTFULL && w_found) begin
          w_state_nxt  = S_GRANT;
          w_grand_nxt  = 4'b0001 << w_sel;
          w_pop_nxt    = 1'b1;
          w_ptr_nxt    = w_ptr_upd;
          w_credit_nxt = w_credit_upd;
        end
      end
      S_GRANT: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_ptr    <= 2'd0;
      r_credit <= ZERO;
      r_grand  <= 4'b0000;
      r_pop    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_credit <= w_credit_nxt;
      r_grand  <= w_grand_nxt;
      r_pop    <= w_pop_nxt;
    end
  end

  assign GRAND     = r_grand;
  assign POPDATOCF = r_pop;

endmodule
